serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that drives one 1-bit full adder cell (fuladder) to compute an N-bit sum bit-serially, LSB first, one bit per clock.
- Captures the operands on a start pulse, shifts them through the adder, accumulates the sum, and reports completion with busy/done.
- Sits between a requester issuing add jobs and the single shared full-adder datapath.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an add; sampled on rising edge
a_in  input  WIDTH  operand A; captured on the accepting edge
b_in  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high while an add is in progress
done  output  1  one-cycle pulse when sum_out/cout are updated
sum_out  output  WIDTH  result of the last completed add
cout  output  1  carry-out of the last completed add

Behaviour:
- Reset: rst_n low forces, asynchronously, state=IDLE, busy=0, done=0, sum_out=0, cout=0, internal shift registers, carry and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge is accepted. On that edge:
  - A_sh<=a_in, B_sh<=b_in, carry<=cin, cnt<=0, state<=RUN, busy<=1.
- RUN: each edge does the following:
  - Drive the full adder with A_sh[0], B_sh[0], carry.
  - Shift A_sh and B_sh right by one.
  - Shift the adder sum bit into S_sh at the MSB; carry<=adder carry; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge): sum_out<=final S_sh, cout<=adder carry, done<=1, busy<=0, state<=DONE.
- Latency: done rises exactly WIDTH edges after the accepting edge. busy is high for exactly WIDTH cycles.
- DONE: lasts one cycle and done is high only in this cycle. Next edge: done<=0.
  - If start=1 on that edge, a new job is accepted with the same actions as in IDLE (back-to-back, no idle gap); state becomes RUN.
  - Otherwise state<=IDLE.
- start while in RUN is ignored: no effect on operands, count or outputs. It is not queued.
- sum_out/cout change only on the completion edge. They hold their value through IDLE and through the RUN of a subsequent job.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic: {cout,sum_out} == a_in + b_in + cin, computed modulo 2^(WIDTH+1). No truncation of the carry.
- cnt width is $clog2(WIDTH)+1, so WIDTH=1 works: the first RUN edge is also the completion edge.
- Reset mid-RUN aborts the job. Outputs return to reset values and no done pulse is produced. After rst_n rises, the block is in IDLE and accepts start on the next edge.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0, start 1 cycle -> busy high 8 cycles; done pulses 8 edges after accept; sum_out=0x00, cout=1.
- WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum_out=0x00, cout=1. Then a=0x12, b=0x34, cin=0 -> sum_out=0x46, cout=0; sum_out holds 0x00 until the second done.
- Start re-asserted for 3 cycles during RUN with different a_in/b_in -> ignored; result equals the first job; exactly one done pulse.
- Back-to-back: start held high continuously, two jobs (0x0F+0xF0+0 and 0x80+0x80+0) -> done pulses 9 edges apart; results 0xFF/0, then 0x00/1.
- Reset asserted 3 edges into a job -> busy, done, sum_out and cout immediately 0, no done pulse; a following job 0x01+0x01+0 gives 0x02/0.
- WIDTH=1, all 8 (a,b,cin) combinations -> {cout,sum_out} matches the full-adder truth table; done 1 edge after each accept.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder sequencer built around a single 1-bit full-adder cell.
// Operands are captured on start, summed LSB first, and the result is published with a done pulse.

module fuladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_sum_s, fa_carry_s;

  fuladder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_sum_s),
    .co (fa_carry_s)
  );

  // Next-state and datapath control; a job may be accepted from IDLE or straight out of DONE.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1'b1;
        b_sh_d = b_sh_q >> 1'b1;
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at position 0.
        s_sh_d            = s_sh_q >> 1'b1;
        s_sh_d[WIDTH-1]   = fa_sum_s;
        carry_d           = fa_carry_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          sum_d   = s_sh_d;
          cout_d  = fa_carry_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the main scenarios
// and a 1-bit instance for the full-adder truth table.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] es;
    logic       ec;
    bit         noise;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic es;
    logic ec;
  } vec1_t;

  vec8_t tbl8[7];
  vec1_t tbl1[8];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One job on the 8-bit instance; noise re-asserts start with junk operands on RUN edges 2..4.
  task automatic run_job(input vec8_t v);
    int done_k;
    int done_cnt;
    done_k   = -1;
    done_cnt = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = v.a; b8 = v.b; cin8 = v.c;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check("busy_after_accept", busy8, 1);
    check("done_after_accept", done8, 0);
    for (int k = 1; k <= W + 2; k++) begin
      start8 = v.noise && (k >= 2) && (k <= 4);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      if (done8) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k < W) begin
        check("busy_during_run", busy8, 1);
        check("done_during_run", done8, 0);
        check("sum_hold", sum8, prev_sum);
        check("cout_hold", cout8, prev_cout);
      end else if (k == W) begin
        check("busy_at_done", busy8, 0);
        check("done_pulse", done8, 1);
        check("sum_result", sum8, v.es);
        check("cout_result", cout8, v.ec);
      end else begin
        check("busy_after_done", busy8, 0);
        check("done_after_done", done8, 0);
      end
    end
    start8 = 1'b0;
    check("done_latency", done_k, W);
    check("done_count", done_cnt, 1);
    prev_sum  = v.es;
    prev_cout = v.ec;
  endtask

  initial begin
    int k1, k2, ndone;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    prev_sum = 8'h00; prev_cout = 1'b0;

    tbl8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl8[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl8[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl8[3] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b1};
    tbl8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl8[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl8[6] = '{8'h3C, 8'h0A, 1'b1, 8'h47, 1'b0, 1'b1};

    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    #22;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_sum1", {sum1, cout1}, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_job(tbl8[i]);

    // Back-to-back: start held high across the DONE cycle starts the second job with no gap.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'hF0; cin8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80;
    k1 = -1; k2 = -1; ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy8 && done8) check("busy_done_overlap", 1, 0);
      if (done8) begin
        ndone++;
        if (k1 < 0) begin
          k1 = k;
          check("b2b_sum1", sum8, 8'hFF);
          check("b2b_cout1", cout8, 0);
        end else begin
          k2 = k;
          check("b2b_sum2", sum8, 8'h00);
          check("b2b_cout2", cout8, 1);
        end
      end
      if (k == 9) begin
        check("b2b_busy_reaccept", busy8, 1);
        start8 = 1'b0;
      end
    end
    check("b2b_first_done", k1, 8);
    check("b2b_second_done", k2, 17);
    check("b2b_done_count", ndone, 2);

    // Leave a nonzero result so the asynchronous reset visibly clears it.
    prev_sum = 8'h00; prev_cout = 1'b1;
    run_job(tbl8[2]);

    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_sum", sum8, 0);
    check("midrst_cout", cout8, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    check("midrst_no_activity", ndone, 0);
    prev_sum = 8'h00; prev_cout = 1'b0;
    run_job('{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0});

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = tbl1[i].a; b1 = tbl1[i].b; cin1 = tbl1[i].c;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~tbl1[i].a; b1 = ~tbl1[i].b; cin1 = ~tbl1[i].c;
      check("w1_busy_accept", busy1, 1);
      check("w1_done_accept", done1, 0);
      @(posedge clk); #1;
      check("w1_done_pulse", done1, 1);
      check("w1_busy_done", busy1, 0);
      check("w1_result", {cout1, sum1}, {tbl1[i].ec, tbl1[i].es});
      @(posedge clk); #1;
      check("w1_done_clear", done1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
